adc_dac_scaler: RTL and testbench
=================================

Name: adc_dac_scaler

Overview:
Parametrised, pipelined ADC-to-DAC conditioning path for the SPGD loop. It boxcar-averages two's-complement ADC samples over 2^LOG2_SAMPS cycles. Each block average is scaled and offset per DAC channel in signed fixed point, then rounded and saturated into unsigned DAC codes. It replaces the fixed single-gain, fixed-offset, unsaturated chain with NUM_CH independent channels, run-time coefficients, saturation flags and a valid strobe.

Parameters:
ADC_WIDTH, 12, ADC sample width, two's complement
DAC_WIDTH, 14, DAC code width, unsigned
LOG2_SAMPS, 10, log2 of samples per averaging block (1..16)
COEF_WIDTH, 32, signed gain/offset coefficient width
COEF_FRAC, 24, fractional bits in gain and offset
NUM_CH, 2, number of DAC channels
DAC_RST_CODE, 8192, DAC code driven from reset until the first result

Ports:
ADC_CLK  in  1  single clock
RST  in  1  asynchronous, active-high reset
ADC_DATA_IN  in  ADC_WIDTH  signed ADC sample, one per clock
EN  in  1  accumulate while high
GAIN  in  NUM_CH*COEF_WIDTH  signed Q(COEF_WIDTH-COEF_FRAC).COEF_FRAC gain per channel; ch0 in LSBs
OFFSET  in  NUM_CH*COEF_WIDTH  signed offset in DAC LSBs, same Q format
COEF_LOAD  in  1  pulse: capture GAIN/OFFSET into shadow registers
DAC_CODE_OUT  out  NUM_CH*DAC_WIDTH  DAC codes; ch0 in LSBs
DAC_VALID  out  1  1-cycle strobe: new codes on DAC_CODE_OUT
SAT  out  NUM_CH  per-channel saturation flag for the current codes
BUSY  out  1  high while a block is accumulating

Behaviour:
- Reset (async assert, released synchronously to ADC_CLK) sets the following:
  - accumulator, sample counter and pipeline valids to 0
  - state = IDLE; BUSY=0; DAC_VALID=0; SAT=0
  - every channel DAC_CODE_OUT = DAC_RST_CODE
  - shadow and active coefficients: gain = 1.0 (1<<COEF_FRAC), offset = 0
- COEF_LOAD copies GAIN/OFFSET into the shadow registers on that edge. Shadow is copied to active only on the average-latch cycle, so one block never mixes coefficient sets.
- FSM states:
  - IDLE: go to ACCUM when EN=1; the first sample is accumulated in that same cycle.
  - ACCUM: each cycle, add the sign-extended sample to an accumulator of ADC_WIDTH+LOG2_SAMPS bits and increment the counter.
  - On sample 2^LOG2_SAMPS: latch avg = acc >>> LOG2_SAMPS (arithmetic shift, floor), clear acc and counter, load active coefficients.
  - If EN is still high, the next block starts on the following cycle with no sample gap; otherwise go to IDLE.
  - EN low mid-block: abort to IDLE, discard the partial sum, and produce no output. Results already in the pipeline still complete.
- BUSY = (state==ACCUM).
- Pipeline per channel, all channels in parallel, fully registered:
  - S1: product p = avg * gain, signed, ADC_WIDTH+COEF_WIDTH bits.
  - S2: s = p + offset, one guard bit; then r = (s + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up).
  - S3: clamp r to [0, 2^DAC_WIDTH-1]; SAT[ch] = 1 if clamped; register codes and assert DAC_VALID.
- Latency: DAC_VALID is high exactly 3 cycles after the avg-latch edge, i.e. 4 cycles after the last sample of the block is presented.
- DAC_CODE_OUT and SAT hold between strobes. Back-to-back blocks give one strobe per 2^LOG2_SAMPS cycles.
- COEF_LOAD on the avg-latch cycle: the new values land in shadow and apply to the next block.
- RST mid-pipeline: all in-flight results are discarded and no DAC_VALID is produced.

Decomposition:
- Shared package spgd_pkg holds:
  - FSM state enum (IDLE, ACCUM)
  - default Q-format constants COEF_FRAC and COEF_ONE = 1<<COEF_FRAC
  - function for the saturating clamp width
- One natural sub-module: dac_scale_ch, the per-channel S1–S3 multiply/offset/round/saturate slice, instantiated NUM_CH times via generate. Accumulator and FSM stay in the top.

Test Plan:
- LOG2_SAMPS=2, ch0 gain=1.0, offset=8192.0, constant input 100 -> DAC_VALID 4 cycles after the 4th sample; ch0 code 8292, SAT=0.
- Samples 1,1,1,2 -> avg 1; samples -1,-1,-1,-2 -> avg -2 (floor). Gain 1.0, offset 0 -> codes 1, then 0 with SAT=1.
- Input -2048: gain 4.0, offset 8192 -> code 0, SAT=0; gain 5.0 -> code 0, SAT=1. Input 2047, gain 8.0 -> 16383, SAT=1.
- Gain 0.5, offset 0, avg 3 -> 1.5 rounds to 2; avg -3 -> -1.5 rounds to -1 -> code 0, SAT=1.
- Checks on EN, COEF_LOAD and block timing:
  - EN dropped after 2 samples -> no strobe; re-assert -> strobe after a full new block.
  - COEF_LOAD mid-block -> new gain appears only on the following block's result.
  - Continuous EN -> strobes exactly every 4 cycles.
- RST asserted one cycle before DAC_VALID -> no strobe; codes = DAC_RST_CODE; SAT=0; BUSY=0; outputs change asynchronously on RST assertion.

Source files
------------

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD ADC-to-DAC conditioning path.
//   state_t    : accumulator FSM states
//   COEF_FRAC  : default number of fractional bits in gain/offset
//   COEF_ONE   : unity gain in the default Q format
//   rnd_width(): width of the rounded (pre-clamp) result of the scale slice
package spgd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int          COEF_FRAC = 24;
  localparam int unsigned COEF_ONE  = 32'd1 << COEF_FRAC;

  // Product is adc_w+coef_w bits, plus one guard bit for the offset add;
  // dropping the fraction leaves the integer part that the clamp inspects.
  function automatic int rnd_width(input int adc_w, input int coef_w,
                                   input int coef_frac);
    return adc_w + coef_w + 1 - coef_frac;
  endfunction

endpackage

// File: rtl/dac_scale_ch.sv
// One DAC channel of the scale path: multiply, offset, round, saturate.
//   clk, rst   : clock, async active-high reset
//   stg_en[0]  : avg/gain/offset valid -> capture product (S1)
//   stg_en[1]  : product valid -> add offset and round (S2)
//   stg_en[2]  : rounded value valid -> clamp and update code/sat (S3)
//   avg        : signed block average
//   gain       : signed Q gain, COEF_FRAC fractional bits
//   offset     : signed offset in DAC LSBs, same Q format
//   code, sat  : unsigned DAC code and clamp flag, held between updates
module dac_scale_ch
  import spgd_pkg::*;
#(
  parameter int ADC_WIDTH    = 12,
  parameter int DAC_WIDTH    = 14,
  parameter int COEF_WIDTH   = 32,
  parameter int COEF_FRAC    = spgd_pkg::COEF_FRAC,
  parameter int DAC_RST_CODE = 8192
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   stg_en,
  input  logic signed [ADC_WIDTH-1:0]  avg,
  input  logic signed [COEF_WIDTH-1:0] gain,
  input  logic signed [COEF_WIDTH-1:0] offset,
  output logic [DAC_WIDTH-1:0]         code,
  output logic                         sat
);

  localparam int P_W = ADC_WIDTH + COEF_WIDTH;
  localparam int S_W = P_W + 1;
  localparam int R_W = rnd_width(ADC_WIDTH, COEF_WIDTH, COEF_FRAC);

  // Adding half an LSB before the arithmetic shift gives round-half-up.
  localparam logic signed [S_W-1:0] HALF     = S_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [R_W-1:0] CODE_MAX = R_W'((1 << DAC_WIDTH) - 1);

  logic signed [P_W-1:0]        prod_q;
  logic signed [COEF_WIDTH-1:0] off_q;
  logic signed [S_W-1:0]        sum_rnd;
  logic signed [R_W-1:0]        rnd_q;

  assign sum_rnd = S_W'(prod_q) + S_W'(off_q) + HALF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      off_q  <= '0;
      rnd_q  <= '0;
      code   <= DAC_WIDTH'(DAC_RST_CODE);
      sat    <= 1'b0;
    end else begin
      // S1: offset travels with the product so a later coefficient swap
      // cannot reach into a result already in flight.
      if (stg_en[0]) begin
        prod_q <= P_W'(avg) * P_W'(gain);
        off_q  <= offset;
      end
      // S2: offset add and round; upper bits after the shift are sign copies.
      if (stg_en[1])
        rnd_q <= R_W'(sum_rnd >>> COEF_FRAC);
      // S3: clamp into the unsigned DAC range.
      if (stg_en[2]) begin
        if (rnd_q[R_W-1]) begin
          code <= '0;
          sat  <= 1'b1;
        end else if (rnd_q > CODE_MAX) begin
          code <= '1;
          sat  <= 1'b1;
        end else begin
          code <= rnd_q[DAC_WIDTH-1:0];
          sat  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/adc_dac_scaler.sv
// ADC-to-DAC conditioning path for the SPGD loop.
// Boxcar-averages 2^LOG2_SAMPS signed ADC samples, then scales and offsets
// the average per channel, rounds and saturates into unsigned DAC codes.
//   ADC_CLK, RST  : clock, async active-high reset
//   ADC_DATA_IN   : signed sample, one per clock while EN is high
//   EN            : accumulate while high; dropping it mid-block aborts
//   GAIN, OFFSET  : per-channel signed Q coefficients, ch0 in LSBs
//   COEF_LOAD     : capture GAIN/OFFSET into shadow registers
//   DAC_CODE_OUT  : per-channel codes, ch0 in LSBs
//   DAC_VALID     : one-cycle strobe with each new set of codes
//   SAT           : per-channel clamp flags for the current codes
//   BUSY          : block accumulation in progress
module adc_dac_scaler
  import spgd_pkg::*;
#(
  parameter int ADC_WIDTH    = 12,
  parameter int DAC_WIDTH    = 14,
  parameter int LOG2_SAMPS   = 10,
  parameter int COEF_WIDTH   = 32,
  parameter int COEF_FRAC    = spgd_pkg::COEF_FRAC,
  parameter int NUM_CH       = 2,
  parameter int DAC_RST_CODE = 8192
) (
  input  logic                           ADC_CLK,
  input  logic                           RST,
  input  logic [ADC_WIDTH-1:0]           ADC_DATA_IN,
  input  logic                           EN,
  input  logic [NUM_CH*COEF_WIDTH-1:0]   GAIN,
  input  logic [NUM_CH*COEF_WIDTH-1:0]   OFFSET,
  input  logic                           COEF_LOAD,
  output logic [NUM_CH*DAC_WIDTH-1:0]    DAC_CODE_OUT,
  output logic                           DAC_VALID,
  output logic [NUM_CH-1:0]              SAT,
  output logic                           BUSY
);

  localparam int ACC_W  = ADC_WIDTH + LOG2_SAMPS;
  localparam int STAGES = 3;

  // Package unity gain rescaled to this instance's fraction width.
  localparam logic [COEF_WIDTH-1:0] GAIN_ONE =
    (COEF_FRAC >= spgd_pkg::COEF_FRAC)
      ? COEF_WIDTH'(COEF_ONE) << (COEF_FRAC - spgd_pkg::COEF_FRAC)
      : COEF_WIDTH'(COEF_ONE) >> (spgd_pkg::COEF_FRAC - COEF_FRAC);

  state_t                          state_q, state_d;
  logic [LOG2_SAMPS-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d, acc_sum;
  logic                            take, last;
  logic signed [ADC_WIDTH-1:0]     avg_q;
  logic [STAGES:0]                 vld_pipe;
  logic [NUM_CH-1:0][COEF_WIDTH-1:0] gain_sh, off_sh, gain_act, off_act;
  logic [NUM_CH-1:0][DAC_WIDTH-1:0]  code;

  // Running sum including the sample on the bus this cycle, so the final
  // sample of a block feeds the average on the same edge it is taken.
  assign acc_sum = acc_q + ACC_W'($signed(ADC_DATA_IN));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (EN) begin
          take    = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (EN) begin
          take = 1'b1;
        end else begin
          // Abort: the partial block is thrown away.
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    last = take && (cnt_q == '1);
    if (take) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Coefficients reach the datapath only alongside a freshly latched
  // average, so a block is always scaled by a single coefficient set.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      gain_sh  <= {NUM_CH{GAIN_ONE}};
      off_sh   <= '0;
      gain_act <= {NUM_CH{GAIN_ONE}};
      off_act  <= '0;
      avg_q    <= '0;
      vld_pipe <= '0;
    end else begin
      if (COEF_LOAD) begin
        gain_sh <= GAIN;
        off_sh  <= OFFSET;
      end
      if (last) begin
        avg_q    <= ADC_WIDTH'(acc_sum >>> LOG2_SAMPS);
        gain_act <= gain_sh;
        off_act  <= off_sh;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], last};
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dac_scale_ch #(
      .ADC_WIDTH   (ADC_WIDTH),
      .DAC_WIDTH   (DAC_WIDTH),
      .COEF_WIDTH  (COEF_WIDTH),
      .COEF_FRAC   (COEF_FRAC),
      .DAC_RST_CODE(DAC_RST_CODE)
    ) u_ch (
      .clk   (ADC_CLK),
      .rst   (RST),
      .stg_en(vld_pipe[STAGES-1:0]),
      .avg   (avg_q),
      .gain  (gain_act[g]),
      .offset(off_act[g]),
      .code  (code[g]),
      .sat   (SAT[g])
    );
  end

  assign DAC_CODE_OUT = code;
  assign DAC_VALID    = vld_pipe[STAGES];
  assign BUSY         = (state_q == ACCUM);

endmodule

// File: tb/tb_adc_dac_scaler.sv
// Directed bench for adc_dac_scaler with 4-sample blocks.
// Coefficients use Q16.16 so an offset of 8192.0 DAC LSBs is representable.
// Channel 1 is kept at gain 2.0, offset 1000.0 throughout unless reset.
module tb_adc_dac_scaler;

  localparam int ADC_W    = 12;
  localparam int DAC_W    = 14;
  localparam int L2       = 2;
  localparam int CW       = 32;
  localparam int CF       = 16;
  localparam int NCH      = 2;
  localparam int RST_CODE = 8192;

  localparam logic [CW-1:0] G1 = 32'h0002_0000;  // 2.0
  localparam logic [CW-1:0] O1 = 32'h03E8_0000;  // 1000.0

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ADC_W-1:0]     adc;
  logic                 en;
  logic [NCH*CW-1:0]    gain, offset;
  logic                 coef_load;
  logic [NCH*DAC_W-1:0] dac_code;
  logic                 dac_valid;
  logic [NCH-1:0]       sat;
  logic                 busy;
  logic [DAC_W-1:0]     ch0, ch1;

  int n_checks = 0;
  int n_fail   = 0;

  assign ch0 = dac_code[DAC_W-1:0];
  assign ch1 = dac_code[2*DAC_W-1:DAC_W];

  always #5 clk = ~clk;

  adc_dac_scaler #(
    .ADC_WIDTH(ADC_W), .DAC_WIDTH(DAC_W), .LOG2_SAMPS(L2), .COEF_WIDTH(CW),
    .COEF_FRAC(CF), .NUM_CH(NCH), .DAC_RST_CODE(RST_CODE)
  ) dut (
    .ADC_CLK(clk), .RST(rst), .ADC_DATA_IN(adc), .EN(en), .GAIN(gain),
    .OFFSET(offset), .COEF_LOAD(coef_load), .DAC_CODE_OUT(dac_code),
    .DAC_VALID(dac_valid), .SAT(sat), .BUSY(busy)
  );

  function automatic logic [CW-1:0] q(input int v);
    return CW'(v) << CF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input logic [CW-1:0] g0, input logic [CW-1:0] o0);
    gain      = {G1, g0};
    offset    = {O1, o0};
    coef_load = 1'b1;
    step();
    coef_load = 1'b0;
  endtask

  task automatic feed(input int v);
    en  = 1'b1;
    adc = ADC_W'(v);
    step();
  endtask

  // Four samples; returns just after the average-latch edge with EN low.
  task automatic block4(input int a, input int b, input int c, input int d);
    feed(a); feed(b); feed(c); feed(d);
    en  = 1'b0;
    adc = '0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (dac_code !== {14'd8192, 14'd8192}) begin n_fail++; $display("FAIL reset_codes: got %h expected %h", dac_code, {14'd8192, 14'd8192}); end
    n_checks++; if (dac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dac_valid); end
    n_checks++; if (sat !== 2'b00) begin n_fail++; $display("FAIL reset_sat: got %b expected 00", sat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    set_coef(q(1), q(8192));
    feed(100);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    feed(100); feed(100); feed(100);
    en = 1'b0;
    step();
    n_checks++; if (dac_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early1: got %b expected 0", dac_valid); end
    step();
    n_checks++; if (dac_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early2: got %b expected 0", dac_valid); end
    step();
    n_checks++; if (dac_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", dac_valid); end
    n_checks++; if (ch0 !== 14'd8292) begin n_fail++; $display("FAIL basic_ch0: got %0d expected 8292", ch0); end
    n_checks++; if (ch1 !== 14'd1200) begin n_fail++; $display("FAIL basic_ch1: got %0d expected 1200", ch1); end
    n_checks++; if (sat !== 2'b00) begin n_fail++; $display("FAIL basic_sat: got %b expected 00", sat); end
    step();
    n_checks++; if (dac_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_shot: got %b expected 0", dac_valid); end
    n_checks++; if (ch0 !== 14'd8292) begin n_fail++; $display("FAIL basic_hold: got %0d expected 8292", ch0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", busy); end
  endtask

  task automatic test_floor();
    set_coef(q(1), '0);
    block4(1, 1, 1, 2);
    step(); step(); step();
    n_checks++; if (dac_valid !== 1'b1) begin n_fail++; $display("FAIL floor_pos_valid: got %b expected 1", dac_valid); end
    n_checks++; if (ch0 !== 14'd1) begin n_fail++; $display("FAIL floor_pos_ch0: got %0d expected 1", ch0); end
    n_checks++; if (ch1 !== 14'd1002) begin n_fail++; $display("FAIL floor_pos_ch1: got %0d expected 1002", ch1); end
    block4(-1, -1, -1, -2);
    step(); step(); step();
    n_checks++; if (ch0 !== 14'd0) begin n_fail++; $display("FAIL floor_neg_ch0: got %0d expected 0", ch0); end
    n_checks++; if (ch1 !== 14'd996) begin n_fail++; $display("FAIL floor_neg_ch1: got %0d expected 996", ch1); end
    n_checks++; if (sat !== 2'b01) begin n_fail++; $display("FAIL floor_neg_sat: got %b expected 01", sat); end
  endtask

  task automatic test_saturate();
    set_coef(q(4), q(8192));
    block4(-2048, -2048, -2048, -2048);
    step(); step(); step();
    n_checks++; if (ch0 !== 14'd0) begin n_fail++; $display("FAIL sat_g4_ch0: got %0d expected 0", ch0); end
    n_checks++; if (sat !== 2'b10) begin n_fail++; $display("FAIL sat_g4_sat: got %b expected 10", sat); end
    set_coef(q(5), q(8192));
    block4(-2048, -2048, -2048, -2048);
    step(); step(); step();
    n_checks++; if (ch0 !== 14'd0) begin n_fail++; $display("FAIL sat_g5_ch0: got %0d expected 0", ch0); end
    n_checks++; if (sat !== 2'b11) begin n_fail++; $display("FAIL sat_g5_sat: got %b expected 11", sat); end
    set_coef(q(8), q(8192));
    block4(2047, 2047, 2047, 2047);
    step(); step(); step();
    n_checks++; if (ch0 !== 14'd16383) begin n_fail++; $display("FAIL sat_hi_ch0: got %0d expected 16383", ch0); end
    n_checks++; if (ch1 !== 14'd5094) begin n_fail++; $display("FAIL sat_hi_ch1: got %0d expected 5094", ch1); end
    n_checks++; if (sat !== 2'b01) begin n_fail++; $display("FAIL sat_hi_sat: got %b expected 01", sat); end
  endtask

  task automatic test_round();
    set_coef(32'h0000_8000, '0);  // 0.5
    block4(3, 3, 3, 3);
    step(); step(); step();
    n_checks++; if (ch0 !== 14'd2) begin n_fail++; $display("FAIL round_pos_ch0: got %0d expected 2", ch0); end
    n_checks++; if (ch1 !== 14'd1006) begin n_fail++; $display("FAIL round_pos_ch1: got %0d expected 1006", ch1); end
    n_checks++; if (sat !== 2'b00) begin n_fail++; $display("FAIL round_pos_sat: got %b expected 00", sat); end
    block4(-3, -3, -3, -3);
    step(); step(); step();
    n_checks++; if (ch0 !== 14'd0) begin n_fail++; $display("FAIL round_neg_ch0: got %0d expected 0", ch0); end
    n_checks++; if (ch1 !== 14'd994) begin n_fail++; $display("FAIL round_neg_ch1: got %0d expected 994", ch1); end
    n_checks++; if (sat !== 2'b01) begin n_fail++; $display("FAIL round_neg_sat: got %b expected 01", sat); end
  endtask

  task automatic test_abort();
    int strobes;
    set_coef(q(1), '0);
    feed(1000);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b expected 1", busy); end
    feed(1000);
    en = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b expected 0", busy); end
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      if (dac_valid === 1'b1) strobes++;
      step();
    end
    n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL abort_no_strobe: got %0d strobes expected 0", strobes); end
    n_checks++; if (ch1 !== 14'd994) begin n_fail++; $display("FAIL abort_hold: got %0d expected 994", ch1); end
    block4(10, 10, 10, 10);
    step(); step(); step();
    n_checks++; if (dac_valid !== 1'b1) begin n_fail++; $display("FAIL abort_restart_valid: got %b expected 1", dac_valid); end
    n_checks++; if (ch0 !== 14'd10) begin n_fail++; $display("FAIL abort_restart_ch0: got %0d expected 10", ch0); end
    n_checks++; if (ch1 !== 14'd1020) begin n_fail++; $display("FAIL abort_restart_ch1: got %0d expected 1020", ch1); end
  endtask

  // Three blocks with EN held high. Gain 2.0 is loaded while the first
  // block's result is still in flight; gain 3.0 is loaded on the second
  // block's latch cycle and so only reaches the third block.
  task automatic test_back_to_back();
    logic          exp_v;
    logic [DAC_W-1:0] exp0, exp1;
    set_coef(q(1), '0);
    for (int c = 1; c <= 15; c++) begin
      en        = (c <= 12);
      adc       = (c <= 4) ? 12'd20 : (c <= 8) ? 12'd30 : (c <= 12) ? 12'd40 : 12'd0;
      coef_load = 1'b0;
      if (c == 6) begin gain = {G1, q(2)}; coef_load = 1'b1; end
      if (c == 8) begin gain = {G1, q(3)}; coef_load = 1'b1; end
      step();
      exp_v = (c == 7) || (c == 11) || (c == 15);
      n_checks++; if (dac_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid cyc %0d: got %b expected %b", c, dac_valid, exp_v); end
      if (exp_v) begin
        exp0 = (c == 7) ? 14'd20 : (c == 11) ? 14'd60 : 14'd120;
        exp1 = (c == 7) ? 14'd1040 : (c == 11) ? 14'd1060 : 14'd1080;
        n_checks++; if (ch0 !== exp0) begin n_fail++; $display("FAIL b2b_ch0 cyc %0d: got %0d expected %0d", c, ch0, exp0); end
        n_checks++; if (ch1 !== exp1) begin n_fail++; $display("FAIL b2b_ch1 cyc %0d: got %0d expected %0d", c, ch1, exp1); end
      end
    end
    coef_load = 1'b0;
  endtask

  task automatic test_rst_mid();
    int strobes;
    block4(50, 50, 50, 50);
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dac_code !== {14'd8192, 14'd8192}) begin n_fail++; $display("FAIL rst_async_codes: got %h expected %h", dac_code, {14'd8192, 14'd8192}); end
    n_checks++; if (sat !== 2'b00) begin n_fail++; $display("FAIL rst_async_sat: got %b expected 00", sat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    step();
    n_checks++; if (dac_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_strobe: got %b expected 0", dac_valid); end
    step();
    rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      if (dac_valid === 1'b1) strobes++;
      step();
    end
    n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL rst_flush: got %0d strobes expected 0", strobes); end
    n_checks++; if (ch0 !== 14'd8192) begin n_fail++; $display("FAIL rst_hold: got %0d expected 8192", ch0); end
    // Coefficients are back at 1.0 / 0 on both channels.
    block4(7, 7, 7, 7);
    step(); step(); step();
    n_checks++; if (dac_valid !== 1'b1) begin n_fail++; $display("FAIL rst_coef_valid: got %b expected 1", dac_valid); end
    n_checks++; if (ch0 !== 14'd7) begin n_fail++; $display("FAIL rst_coef_ch0: got %0d expected 7", ch0); end
    n_checks++; if (ch1 !== 14'd7) begin n_fail++; $display("FAIL rst_coef_ch1: got %0d expected 7", ch1); end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    adc       = '0;
    gain      = '0;
    offset    = '0;
    coef_load = 1'b0;
    test_reset();
    test_basic();
    test_floor();
    test_saturate();
    test_round();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
